// File: rtl/regfile_dumper_pkg.sv
// ---------------------------------------------------------------------------
// regfile_dumper_pkg
//
// Shared definitions for the register-file debug dumper and the register file
// it reads. It holds the default register-file geometry, so both blocks agree
// on address and data width. It also holds the dumper's state enumeration.
//
// Contents:
//   REGFILE_ADDR_W  default register address width (32 registers)
//   REGFILE_DATA_W  default register data width
//   dumpState_e     dumper FSM states: IDLE, FETCH, SEND, CSUM, DONE
// ---------------------------------------------------------------------------
package regfile_dumper_pkg;

  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_DATA_W = 32;

  // CSUM exists in the encoding even when the checksum is compiled out. That
  // build simply never enters it.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } dumpState_e;

endpackage

// File: rtl/regfile_dumper.sv
// ---------------------------------------------------------------------------
// regfile_dumper
//
// Debug read-out engine for the register file. A start pulse makes the block
// walk every register address through the register file's asynchronous test
// read port. Each word goes out on a valid/ready stream, tagged with its
// register index, and the final word is flagged with out_last.
//
// Optional feature (compile-time macro REGDUMP_CHECKSUM_EN):
//   When defined, the block keeps a running XOR of every captured word. It
//   emits that XOR as one extra word after the last register, with
//   out_addr=0 and out_last=1. In that build the last register's word has
//   out_last=0.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   one-cycle dump request, accepted only when idle
//   busy       out  high while a dump is in progress
//   done       out  one-cycle pulse after the final stream handshake
//   test_addr  out  registered address to the register-file test port
//   test_data  in   combinational register-file read data for test_addr
//   out_valid  out  stream word valid
//   out_ready  in   downstream ready
//   out_data   out  stream word
//   out_addr   out  register index of out_data
//   out_last   out  final word of the dump
// ---------------------------------------------------------------------------
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0] test_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  dumpState_e r_state;
  dumpState_e w_nextState;

  logic [ADDR_W-1:0] r_addrCnt;
  logic [ADDR_W-1:0] r_testAddr;
  logic [DATA_W-1:0] r_outData;
  logic [ADDR_W-1:0] r_outAddr;
  logic              r_outValid;
  logic              r_outLast;
  logic              r_busy;
  logic              r_done;

  logic w_handshake;
  logic w_lastAddr;
  logic w_accept;
  logic w_capture;
  logic w_advance;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              w_csumLoad;
`endif

  // A handshake only counts while a word is actually presented. A ready
  // signal with no valid word is ignored.
  assign w_handshake = r_outValid & out_ready;
  assign w_lastAddr  = (r_addrCnt == LAST_ADDR);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the one-cycle strobes that steer the datapath.
  // start is looked at only in IDLE. A start pulse during a dump, or in the
  // DONE cycle, is therefore dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    w_csumLoad  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        w_capture   = 1'b1;
        w_nextState = SEND;
      end
      SEND: begin
        if (w_handshake) begin
          if (!w_lastAddr) begin
            w_advance   = 1'b1;
            w_nextState = FETCH;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            w_csumLoad  = 1'b1;
            w_nextState = CSUM;
`else
            w_nextState = DONE;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        if (w_handshake) begin
          w_nextState = DONE;
        end
      end
`endif
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The address counter and the test-port address move together, and only on
  // the edge that enters FETCH. The register file therefore has a full cycle
  // to settle before capture. Both stop at the last address instead of
  // wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addrCnt  <= '0;
      r_testAddr <= '0;
    end else if (w_accept) begin
      r_addrCnt  <= '0;
      r_testAddr <= '0;
    end else if (w_advance) begin
      r_addrCnt  <= r_addrCnt + 1'b1;
      r_testAddr <= r_testAddr + 1'b1;
    end
  end

  // Output word register. The word is captured at the end of FETCH, so a
  // register-file write landing on that same edge is not seen. Once a word is
  // presented, every out_* field holds until the handshake, which clears
  // valid. With the checksum enabled, the last register's handshake reloads
  // the register with the checksum word straight away, with no gap cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outData  <= '0;
      r_outAddr  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_capture) begin
      r_outData  <= test_data;
      r_outAddr  <= r_addrCnt;
      r_outValid <= 1'b1;
      r_outLast  <= w_lastAddr && !CSUM_EN;
`ifdef REGDUMP_CHECKSUM_EN
    end else if (w_csumLoad) begin
      r_outData  <= r_csum ^ '0;
      r_outAddr  <= '0;
      r_outValid <= 1'b1;
      r_outLast  <= 1'b1;
`endif
    end else if (w_handshake) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // Running XOR of every captured word. It is cleared when a new dump is
  // accepted, so a dump that was cut short by reset leaves nothing behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_capture) begin
      r_csum <= r_csum ^ test_data;
    end
  end
`endif

  // busy and done are registered from the next state. busy stays high
  // through the DONE cycle, and done is high only in that cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_nextState != IDLE);
      r_done <= (w_nextState == DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign test_addr = r_testAddr;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_addr  = r_outAddr;
  assign out_last  = r_outLast;

endmodule
